// File: rtl/seq_mul_unit_pkg.sv
// Shared ALU control codes and the sequential multiplier state encoding.
package seq_mul_unit_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_MUL = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-add signed multiplier: iterates on operand magnitudes and
// applies the sign once on the final cycle, stalling the pipe via busy_o.
module seq_mul_unit
   import seq_mul_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] prod_hi_o
);

   mul_state_t         state, state_nxt;
   logic [WIDTH-1:0]   mcand, mplier;
   logic               neg;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod_fin;
   logic [WIDTH:0]     psum;
   logic [CNT_W-1:0]   cnt;
   logic               accept, last;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // busy/done decode straight off the state register, so no input reaches them
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i && ALUCtrl_i == ALU_MUL) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Carry out of the upper-half add lands in the top bit after the shift.
   always_comb begin
      psum     = mplier[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                           : {1'b0, acc[2*WIDTH-1:WIDTH]};
      acc_nxt  = (2*WIDTH)'({psum, acc[WIDTH-1:0]} >> 1);
      prod_fin = neg ? -acc_nxt : acc_nxt;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcand     <= '0;
         mplier    <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         result_o  <= '0;
         prod_hi_o <= '0;
      end else if (accept) begin
         // -(most negative) wraps to itself, which is the correct unsigned magnitude
         mcand  <= src1_i[WIDTH-1] ? -src1_i : src1_i;
         mplier <= src2_i[WIDTH-1] ? -src2_i : src2_i;
         neg    <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
         acc    <= '0;
         cnt    <= '0;
      end else if (state == ST_RUN) begin
         acc    <= acc_nxt;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (last) begin
            result_o  <= prod_fin[WIDTH-1:0];
            prod_hi_o <= prod_fin[2*WIDTH-1:WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed vector table plus corner-case sequences and a random back-to-back run.
module tb_seq_mul_unit;
   import seq_mul_unit_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   logic         clk, rst_n, start;
   logic [3:0]   ctrl;
   logic [W-1:0] src1, src2;
   logic         busy, done;
   logic [W-1:0] res_lo, res_hi;

   int passed = 0, total = 0;
   int n_ops = 0, done_seen = 0;
   bit in_done = 0;
   logic [2*W-1:0] last_p = '0;

   seq_mul_unit dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .ALUCtrl_i(ctrl),
      .src1_i(src1), .src2_i(src2), .busy_o(busy), .done_o(done),
      .result_o(res_lo), .prod_hi_o(res_hi)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_seen++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      if (n > 0) in_done = 0;
   endtask

   // Called at a negedge; returns at the negedge where done_o is seen.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string nm);
      int lat = 0;
      src1 = a; src2 = b; ctrl = ALU_MUL; start = 1;
      for (int i = 1; i <= W + 6; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      start = 0;
      n_ops++;
      chk({nm, " latency"}, 64'(lat), in_done ? 64'(W + 2) : 64'(W + 1));
      chk({nm, " busy@done"}, 64'(busy), 64'd1);
      chk({nm, " product"}, {res_hi, res_lo}, exp);
      last_p  = exp;
      in_done = 1;
   endtask

   initial begin
      vec_t vecs[7];
      int   lat;
      bit   seen_b, seen_d;
      logic [W-1:0] ra, rb;
      logic [2*W-1:0] rp;

      vecs[0] = '{32'd7,        32'd6,        64'h00000000_0000002A};
      vecs[1] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
      vecs[2] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[3] = '{32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
      vecs[5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF_80000001};
      vecs[6] = '{32'h12345678, 32'd0,        64'h00000000_00000000};

      rst_n = 0; start = 0; ctrl = ALU_ADD; src1 = '0; src2 = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset result", 64'(res_lo), 64'd0);
      chk("reset hi", 64'(res_hi), 64'd0);
      rst_n = 1;
      idle(1);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
         idle(2);
      end

      // Non-MUL code with start high must be ignored
      seen_b = 0; seen_d = 0;
      src1 = 32'd5; src2 = 32'd5; ctrl = 4'b0010; start = 1;
      repeat (6) begin
         @(negedge clk);
         if (busy) seen_b = 1;
         if (done) seen_d = 1;
      end
      start = 0;
      chk("nonmul busy", 64'(seen_b), 64'd0);
      chk("nonmul done", 64'(seen_d), 64'd0);
      chk("nonmul hold", {res_hi, res_lo}, last_p);
      idle(1);

      // A second MUL start pulsed mid-RUN is dropped
      lat = 0;
      src1 = 32'd11; src2 = 32'd13; ctrl = ALU_MUL; start = 1;
      for (int i = 1; i <= W + 6; i++) begin
         @(negedge clk);
         if (i == 3) start = 0;
         if (i == 5) begin start = 1; src1 = 32'd100; src2 = 32'd200; end
         if (i == 6) start = 0;
         if (done) begin lat = i; break; end
      end
      start = 0;
      n_ops++;
      chk("midrun latency", 64'(lat), 64'(W + 1));
      chk("midrun product", {res_hi, res_lo}, 64'd143);
      seen_d = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) seen_d = 1;
      end
      chk("midrun extra done", 64'(seen_d), 64'd0);
      chk("midrun idle", 64'(busy), 64'd0);
      in_done = 0;

      // Reset in the middle of RUN aborts with everything cleared
      src1 = 32'd1000; src2 = 32'd3; ctrl = ALU_MUL; start = 1;
      @(negedge clk);
      chk("abort accepted", 64'(busy), 64'd1);
      repeat (9) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort result", 64'(res_lo), 64'd0);
      chk("abort hi", 64'(res_hi), 64'd0);
      start = 0;
      @(negedge clk);
      rst_n = 1;
      seen_d = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) seen_d = 1;
      end
      chk("abort no done", 64'(seen_d), 64'd0);
      in_done = 0;
      run_op(32'hFFFFFF9C, 32'd50, 64'hFFFFFFFF_FFFFEC78, "post-reset");
      idle(3);

      // Random operands at minimum spacing
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom;
         rb = $urandom;
         rp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
         run_op(ra, rb, rp, $sformatf("rand%0d", n));
      end
      idle(4);
      chk("done per accept", 64'(done_seen), 64'(n_ops));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
